// File: rtl/tag_pkg.sv
// Shared constants, tag type and controller state encoding for the tag allocation path.
package tag_pkg;

  localparam int DSIZE = 5;
  localparam int NTAGS = 32;
  localparam int NREQ  = 4;

  typedef logic [DSIZE-1:0] tag_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Round-robin pointer advance: one past the granted index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational, grants the first set req at or after ptr (ascending, wrapping).
// Zero latency; no internal state, the caller owns and advances ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tag_alloc_ctrl.sv
// Tag FIFO controller: fills tags 0..NTAGS-1 after reset, then muxes retire returns and RR-grants one tag/cycle.
// Grants/writes are zero-latency; empty FIFO stalls requesters, full FIFO flags tag_err. Option: TAGCTL_STATS_EN.
module tag_alloc_ctrl #(
  parameter int DSIZE = tag_pkg::DSIZE,
  parameter int NTAGS = tag_pkg::NTAGS,
  parameter int NREQ  = tag_pkg::NREQ
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  disp_req,
  output logic [NREQ-1:0]  disp_gnt,
  output logic [DSIZE-1:0] disp_tag,
  input  logic [DSIZE-1:0] rb_tag,
  input  logic             rb_tag_valid,
  input  logic [DSIZE-1:0] fifo_tag_out,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_rd_en,
  output logic [DSIZE-1:0] fifo_wr_tag,
  output logic             fifo_wr_valid,
  output logic             init_done,
  output logic             tag_err
`ifdef TAGCTL_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      grant_cnt
`endif
);

  import tag_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [DSIZE-1:0] LAST_TAG = DSIZE'(NTAGS - 1);

  state_e           state;
  logic [DSIZE-1:0] init_cnt;
  logic [IW-1:0]    rr_ptr;
  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             in_run;
  logic             grant_any;
  logic             init_wr;

  assign in_run = (state == RUN);

  // Requests are masked until RUN and while the FIFO has nothing to hand out.
  assign arb_req = (in_run && !fifo_empty) ? disp_req : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign disp_gnt   = arb_gnt;
  assign grant_any  = |arb_gnt;
  assign fifo_rd_en = grant_any;
  assign disp_tag   = fifo_tag_out;
  assign init_wr    = !in_run && !fifo_full;

  always_comb begin
    if (in_run) begin
      fifo_wr_tag   = rb_tag;
      fifo_wr_valid = rb_tag_valid;
    end else begin
      fifo_wr_tag   = init_cnt;
      fifo_wr_valid = !fifo_full;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (init_wr) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_TAG) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= IW'(rr_next(int'(arb_idx), NREQ));
    end
  end

  // A return during fill is dropped; a return into a full FIFO is presented but lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      init_done <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      init_done <= in_run;
      if (rb_tag_valid && (!in_run || fifo_full)) begin
        tag_err <= 1'b1;
      end
    end
  end

`ifdef TAGCTL_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (in_run && (|disp_req) && fifo_empty && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (grant_any) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Directed bench for tag_alloc_ctrl: fill, round-robin, stall, retire path, errors and reset restart.
module tb_tag_alloc_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] disp_req = '0;
  logic [3:0] disp_gnt;
  logic [4:0] disp_tag;
  logic [4:0] rb_tag = '0;
  logic       rb_tag_valid = 1'b0;
  logic [4:0] fifo_tag_out = '0;
  logic       fifo_empty = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_rd_en;
  logic [4:0] fifo_wr_tag;
  logic       fifo_wr_valid;
  logic       init_done;
  logic       tag_err;
`ifdef TAGCTL_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] grant_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tag_alloc_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .disp_req      (disp_req),
    .disp_gnt      (disp_gnt),
    .disp_tag      (disp_tag),
    .rb_tag        (rb_tag),
    .rb_tag_valid  (rb_tag_valid),
    .fifo_tag_out  (fifo_tag_out),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_wr_tag   (fifo_wr_tag),
    .fifo_wr_valid (fifo_wr_valid),
    .init_done     (init_done),
    .tag_err       (tag_err)
`ifdef TAGCTL_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .grant_cnt     (grant_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    disp_req = 4'b1111;
    #1;
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
    checks++; if (disp_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", disp_gnt); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (fifo_wr_tag !== 5'd0) begin failures++; $display("FAIL reset_wr_tag got=%0d exp=0", fifo_wr_tag); end
    step();
    step();
  endtask

  task automatic test_init_err_restart();
    reset = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rb_tag = 5'd17;
    rb_tag_valid = 1'b1;
    #1;
    checks++; if (fifo_wr_tag !== 5'd9) begin failures++; $display("FAIL init_rb_drop_tag got=%0d exp=9", fifo_wr_tag); end
    checks++; if (fifo_wr_valid !== 1'b1) begin failures++; $display("FAIL init_rb_drop_vld got=%b exp=1", fifo_wr_valid); end
    step();
    rb_tag_valid = 1'b0;
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL init_rb_err got=%b exp=1", tag_err); end
    fifo_full = 1'b1;
    #1;
    checks++; if (fifo_wr_valid !== 1'b0) begin failures++; $display("FAIL init_full_vld got=%b exp=0", fifo_wr_valid); end
    step();
    checks++; if (fifo_wr_tag !== 5'd10) begin failures++; $display("FAIL init_full_hold got=%0d exp=10", fifo_wr_tag); end
    fifo_full = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL restart_tag_err got=%b exp=0", tag_err); end
    checks++; if (fifo_wr_tag !== 5'd0) begin failures++; $display("FAIL restart_wr_tag got=%0d exp=0", fifo_wr_tag); end
    step();
  endtask

  task automatic test_init_fill();
    disp_req = 4'b1111;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++; if (fifo_wr_tag !== 5'(i)) begin failures++; $display("FAIL fill_tag[%0d] got=%0d exp=%0d", i, fifo_wr_tag, i); end
      checks++; if (fifo_wr_valid !== 1'b1) begin failures++; $display("FAIL fill_vld[%0d] got=%b exp=1", i, fifo_wr_valid); end
      checks++; if (disp_gnt !== 4'b0000) begin failures++; $display("FAIL fill_gnt[%0d] got=%b exp=0000", i, disp_gnt); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL fill_done[%0d] got=%b exp=0", i, init_done); end
      step();
    end
    disp_req = 4'b0000;
    #1;
    checks++; if (fifo_wr_valid !== 1'b0) begin failures++; $display("FAIL run_idle_vld got=%b exp=0", fifo_wr_valid); end
    step();
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%b exp=1", init_done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [4:0] exp_t;
    disp_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_t = 5'(3 + k);
      fifo_tag_out = exp_t;
      #1;
      checks++; if (disp_gnt !== exp_g) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, disp_gnt, exp_g); end
      checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL rr_rd_en[%0d] got=%b exp=1", k, fifo_rd_en); end
      checks++; if (disp_tag !== exp_t) begin failures++; $display("FAIL rr_tag[%0d] got=%0d exp=%0d", k, disp_tag, exp_t); end
      step();
    end
  endtask

  task automatic test_sparse();
    disp_req = 4'b0010;
    #1;
    checks++; if (disp_gnt !== 4'b0010) begin failures++; $display("FAIL sparse_setup got=%b exp=0010", disp_gnt); end
    step();
    disp_req = 4'b0011;
    #1;
    checks++; if (disp_gnt !== 4'b0001) begin failures++; $display("FAIL sparse_wrap got=%b exp=0001", disp_gnt); end
    step();
    #1;
    checks++; if (disp_gnt !== 4'b0010) begin failures++; $display("FAIL sparse_next got=%b exp=0010", disp_gnt); end
    step();
  endtask

  task automatic test_empty_stall();
    disp_req = 4'b0100;
    fifo_empty = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      #1;
      checks++; if (disp_gnt !== 4'b0000) begin failures++; $display("FAIL stall_gnt[%0d] got=%b exp=0000", s, disp_gnt); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en[%0d] got=%b exp=0", s, fifo_rd_en); end
      step();
`ifdef TAGCTL_STATS_EN
      checks++; if (stall_cnt !== 16'(s)) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", s, stall_cnt, s); end
`endif
    end
`ifdef TAGCTL_STATS_EN
    checks++; if (grant_cnt !== 16'd8) begin failures++; $display("FAIL grant_cnt_a got=%0d exp=8", grant_cnt); end
`endif
    fifo_empty = 1'b0;
    #1;
    checks++; if (disp_gnt !== 4'b0100) begin failures++; $display("FAIL unstall_gnt got=%b exp=0100", disp_gnt); end
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL unstall_rd_en got=%b exp=1", fifo_rd_en); end
    step();
  endtask

  task automatic test_retire();
    disp_req = 4'b1000;
    fifo_tag_out = 5'd22;
    rb_tag = 5'd17;
    rb_tag_valid = 1'b1;
    #1;
    checks++; if (fifo_wr_tag !== 5'd17) begin failures++; $display("FAIL rb_wr_tag got=%0d exp=17", fifo_wr_tag); end
    checks++; if (fifo_wr_valid !== 1'b1) begin failures++; $display("FAIL rb_wr_vld got=%b exp=1", fifo_wr_valid); end
    checks++; if (disp_gnt !== 4'b1000) begin failures++; $display("FAIL rb_gnt got=%b exp=1000", disp_gnt); end
    checks++; if (disp_tag !== 5'd22) begin failures++; $display("FAIL rb_disp_tag got=%0d exp=22", disp_tag); end
    step();
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL rb_no_err got=%b exp=0", tag_err); end
    disp_req = 4'b0000;
    fifo_full = 1'b1;
    #1;
    checks++; if (fifo_wr_valid !== 1'b1) begin failures++; $display("FAIL full_wr_vld got=%b exp=1", fifo_wr_valid); end
    step();
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL full_err got=%b exp=1", tag_err); end
    rb_tag_valid = 1'b0;
    fifo_full = 1'b0;
    step();
    checks++; if (tag_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", tag_err); end
`ifdef TAGCTL_STATS_EN
    checks++; if (grant_cnt !== 16'd10) begin failures++; $display("FAIL grant_cnt_b got=%0d exp=10", grant_cnt); end
`endif
  endtask

  task automatic test_reset_run();
    disp_req = 4'b1111;
    reset = 1'b0;
    #1;
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL rrun_tag_err got=%b exp=0", tag_err); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rrun_done got=%b exp=0", init_done); end
    checks++; if (disp_gnt !== 4'b0000) begin failures++; $display("FAIL rrun_gnt got=%b exp=0000", disp_gnt); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rrun_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (fifo_wr_tag !== 5'd0) begin failures++; $display("FAIL rrun_wr_tag got=%0d exp=0", fifo_wr_tag); end
`ifdef TAGCTL_STATS_EN
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rrun_stall got=%0d exp=0", stall_cnt); end
`endif
    reset = 1'b1;
    step();
    checks++; if (fifo_wr_tag !== 5'd1) begin failures++; $display("FAIL rrun_refill got=%0d exp=1", fifo_wr_tag); end
  endtask

  initial begin
    test_reset();
    test_init_err_restart();
    test_init_fill();
    test_round_robin();
    test_sparse();
    test_empty_stall();
    test_retire();
    test_reset_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
